typed_text_writer: RTL and testbench

TYPED_TEXT_WRITER -- requirements
Module: typed_text_writer

---
 rtl/typeracer_pkg.sv | 25 ++
 rtl/typed_text_writer.sv | 159 +++++++++++++++
 tb/tb_typed_text_writer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/typeracer_pkg.sv
// Shared constants for the typing-game blocks.
//
// Contents:
//   TR_MAX_LEN    - default number of character slots in a text buffer
//   TR_CW         - default bits per character code
//   TR_LETTER_MAX - highest letter code (26 = Z); codes above it are ignored
//   TR_KEYS_MAX   - saturation value of the per-round key counter
//   ST_*          - round state encoding (IDLE / TYPING / DONE)
//   CODE_BLANK    - code stored in an empty text slot
//   CODE_BKSP     - key code that means backspace
package typeracer_pkg;

    localparam int TR_MAX_LEN    = 25;
    localparam int TR_CW         = 5;
    localparam int TR_LETTER_MAX = 26;
    localparam int TR_KEYS_MAX   = 999;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TYPING = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [TR_CW-1:0] CODE_BLANK = '0;
    localparam logic [TR_CW-1:0] CODE_BKSP  = '0;

endpackage

// File: rtl/typed_text_writer.sv
// Typing-round text buffer: accepts letter / backspace key events, keeps the
// typed text, its length, the length of the prefix matching a latched target,
// and a saturating count of accepted key events. The round finishes (DONE)
// once the matching prefix covers the whole target.
//
// Ports:
//   clk        - single clock, all state changes on rising edge
//   rst        - synchronous active-high reset (beats start and key events)
//   start      - one-cycle pulse: clear buffer/counters, latch target, TYPING
//   target_len - number of target characters, sampled on start
//   target     - packed target text, slot i at [i*CW +: CW], sampled on start
//   key_valid  - key event offered
//   key_code   - 1..26 letter, 0 backspace, 27..31 ignored
//   key_ready  - event accepted when key_valid && key_ready
//   text       - registered packed typed text, unused slots 0
//   tot        - number of typed characters
//   correct    - length of typed prefix that matches the target
//   keys       - accepted letter/backspace events this round, saturates at 999
//   done       - high while in DONE
module typed_text_writer
    import typeracer_pkg::*;
#(
    parameter int MAX_LEN = TR_MAX_LEN,
    parameter int CW      = TR_CW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [5:0]            target_len,
    input  logic [MAX_LEN*CW-1:0] target,
    input  logic                  key_valid,
    input  logic [CW-1:0]         key_code,
    output logic                  key_ready,
    output logic [MAX_LEN*CW-1:0] text,
    output logic [5:0]            tot,
    output logic [5:0]            correct,
    output logic [9:0]            keys,
    output logic                  done
);

    logic [1:0]            state_reg, state_next;
    logic [MAX_LEN*CW-1:0] text_reg, text_next;
    logic [MAX_LEN*CW-1:0] target_reg;
    logic [5:0]            target_len_reg;
    logic [5:0]            tot_reg, tot_next;
    logic [5:0]            correct_reg, correct_next;
    logic [9:0]            keys_reg, keys_next;

    logic accept;
    logic is_letter;
    logic is_bksp;
    logic letter_wr;
    logic bksp_clr;
    logic counted;
    logic letter_match;

    // Per-slot decodes of the current write pointer (tot_reg).
    logic [MAX_LEN-1:0] slot_at_tot;
    logic [MAX_LEN-1:0] slot_below_tot;
    logic [MAX_LEN-1:0] target_hit;

    // A start pulse takes the cycle, so no key can be consumed alongside it.
    assign key_ready = (state_reg == ST_TYPING) && !start;
    assign accept    = key_valid && key_ready;

    always_comb begin
        is_letter = (key_code != CW'(CODE_BKSP)) && (int'(key_code) <= TR_LETTER_MAX);
        is_bksp   = (key_code == CW'(CODE_BKSP));
        // Codes 27..31 are consumed but fall through every branch below.
        counted   = accept && (is_letter || is_bksp);
        letter_wr = accept && is_letter && (tot_reg < 6'(MAX_LEN));
        bksp_clr  = accept && is_bksp && (tot_reg != 6'd0);
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_slot
            assign slot_at_tot[gi]    = (tot_reg == 6'(gi));
            assign slot_below_tot[gi] = (tot_reg == 6'(gi + 1));
            assign target_hit[gi]     = slot_at_tot[gi] &&
                                        (target_reg[gi*CW +: CW] == key_code);

            assign text_next[gi*CW +: CW] =
                start                                 ? CW'(CODE_BLANK) :
                (letter_wr && slot_at_tot[gi])        ? key_code :
                (bksp_clr  && slot_below_tot[gi])     ? CW'(CODE_BLANK) :
                                                        text_reg[gi*CW +: CW];
        end
    endgenerate

    assign letter_match = |target_hit;

    always_comb begin
        tot_next     = tot_reg;
        correct_next = correct_reg;
        keys_next    = keys_reg;
        state_next   = state_reg;

        if (start) begin
            tot_next     = 6'd0;
            correct_next = 6'd0;
            keys_next    = 10'd0;
            state_next   = ST_TYPING;
        end else begin
            if (letter_wr) begin
                tot_next = tot_reg + 6'd1;
                // Only extend the match while the whole buffer is still a
                // matching prefix; after a typo correct stays put.
                if ((correct_reg == tot_reg) && letter_match) begin
                    correct_next = correct_reg + 6'd1;
                end
            end else if (bksp_clr) begin
                tot_next = tot_reg - 6'd1;
                if (correct_reg == tot_reg) begin
                    correct_next = correct_reg - 6'd1;
                end
            end

            if (counted && (keys_reg != 10'(TR_KEYS_MAX))) begin
                keys_next = keys_reg + 10'd1;
            end

            // Compare against the post-update count so DONE shows up together
            // with the final correct value.
            if ((state_reg == ST_TYPING) && (correct_next == target_len_reg)) begin
                state_next = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            text_reg       <= '0;
            tot_reg        <= 6'd0;
            correct_reg    <= 6'd0;
            keys_reg       <= 10'd0;
            target_reg     <= '0;
            target_len_reg <= 6'd0;
        end else begin
            state_reg   <= state_next;
            text_reg    <= text_next;
            tot_reg     <= tot_next;
            correct_reg <= correct_next;
            keys_reg    <= keys_next;
            if (start) begin
                target_reg     <= target;
                target_len_reg <= target_len;
            end
        end
    end

    assign text    = text_reg;
    assign tot     = tot_reg;
    assign correct = correct_reg;
    assign keys    = keys_reg;
    assign done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_typed_text_writer.sv
// Self-checking bench for typed_text_writer: directed scenarios plus random
// key streams, every output compared each cycle with a reference model that
// keeps the typed text as an array and derives "correct" as the longest
// common prefix of typed text and target.
module tb_typed_text_writer;

    localparam int ML = 25;
    localparam int W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [5:0]        target_len = '0;
    logic [ML*W-1:0]   target = '0;
    logic              key_valid = 1'b0;
    logic [W-1:0]      key_code = '0;
    logic              key_ready;
    logic [ML*W-1:0]   text;
    logic [5:0]        tot;
    logic [5:0]        correct;
    logic [9:0]        keys;
    logic              done;

    typed_text_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .target_len (target_len),
        .target     (target),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .text       (text),
        .tot        (tot),
        .correct    (correct),
        .keys       (keys),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 = idle, 1 = typing, 2 = done
    int m_phase = 0;
    int m_text[ML];
    int m_target[ML];
    int m_tot = 0;
    int m_keys = 0;
    int m_tlen = 0;
    bit m_known = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_correct();
        int n = 0;
        while (n < m_tot && m_text[n] == m_target[n]) n++;
        return n;
    endfunction

    function automatic logic [ML*W-1:0] m_text_packed();
        logic [ML*W-1:0] v = '0;
        for (int i = 0; i < ML; i++) v[i*W +: W] = W'(m_text[i]);
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit s, input logic [5:0] tl,
                              input logic [ML*W-1:0] tg, input bit kv, input int kc);
        if (r) begin
            m_phase = 0; m_tot = 0; m_keys = 0; m_tlen = 0;
            for (int i = 0; i < ML; i++) begin m_text[i] = 0; m_target[i] = 0; end
            m_known = 1'b1;
        end else if (s) begin
            m_phase = 1; m_tot = 0; m_keys = 0; m_tlen = int'(tl);
            for (int i = 0; i < ML; i++) begin m_text[i] = 0; m_target[i] = int'(tg[i*W +: W]); end
        end else if (m_phase == 1) begin
            if (kv && kc >= 1 && kc <= 26) begin
                if (m_tot < ML) begin m_text[m_tot] = kc; m_tot++; end
                if (m_keys < 999) m_keys++;
            end else if (kv && kc == 0) begin
                if (m_tot > 0) begin m_tot--; m_text[m_tot] = 0; end
                if (m_keys < 999) m_keys++;
            end
            if (m_correct() == m_tlen) m_phase = 2;
        end
    endtask

    // One clock: drive inputs, check key_ready mid-cycle, advance the model on
    // the edge, then compare every registered output just after the edge.
    task automatic cycle(input string tag, input bit r, input bit s, input logic [5:0] tl,
                         input logic [ML*W-1:0] tg, input bit kv, input int kc);
        rst = r; start = s; target_len = tl; target = tg; key_valid = kv; key_code = W'(kc);
        @(negedge clk);
        if (m_known) chk({tag, ".key_ready"}, 128'(key_ready), 128'(m_phase == 1 && !s));
        @(posedge clk);
        model_edge(r, s, tl, tg, kv, kc);
        #1;
        chk({tag, ".text"},    128'(text),    128'(m_text_packed()));
        chk({tag, ".tot"},     128'(tot),     128'(m_tot));
        chk({tag, ".correct"}, 128'(correct), 128'(m_correct()));
        chk({tag, ".keys"},    128'(keys),    128'(m_keys));
        chk({tag, ".done"},    128'(done),    128'(m_phase == 2));
    endtask

    logic [ML*W-1:0] cat_tg;
    logic [ML*W-1:0] tg;
    int len, kc, p, q;
    bit kv, st;

    initial begin
        cat_tg = '0;
        cat_tg[4:0] = 5'd3; cat_tg[9:5] = 5'd1; cat_tg[14:10] = 5'd20;

        // Reset state
        cycle("reset", 1, 0, 0, '0, 0, 0);
        chk("reset.key_ready", 128'(key_ready), 128'(0));
        cycle("idle", 0, 0, 0, '0, 1, 3);
        chk("idle_frozen.tot", 128'(tot), 128'(0));

        // CAT typed correctly
        cycle("cat", 0, 1, 6'd3, cat_tg, 0, 0);
        cycle("cat", 0, 0, 6'd3, cat_tg, 1, 3);
        cycle("cat", 0, 0, 6'd3, cat_tg, 1, 1);
        cycle("cat", 0, 0, 6'd3, cat_tg, 1, 20);
        chk("cat.tot_const", 128'(tot), 128'(3));
        chk("cat.correct_const", 128'(correct), 128'(3));
        chk("cat.done_const", 128'(done), 128'(1));
        chk("cat.keys_const", 128'(keys), 128'(3));
        cycle("cat_frozen", 0, 0, 6'd3, cat_tg, 1, 5);

        // Typo then backspaces
        cycle("typo", 0, 1, 6'd3, cat_tg, 0, 0);
        cycle("typo", 0, 0, 6'd3, cat_tg, 1, 3);
        cycle("typo", 0, 0, 6'd3, cat_tg, 1, 24);
        cycle("typo", 0, 0, 6'd3, cat_tg, 1, 1);
        chk("typo.tot_const", 128'(tot), 128'(3));
        chk("typo.correct_const", 128'(correct), 128'(1));
        cycle("typo", 0, 0, 6'd3, cat_tg, 1, 0);
        cycle("typo", 0, 0, 6'd3, cat_tg, 1, 0);
        chk("typo_bs.tot_const", 128'(tot), 128'(1));
        chk("typo_bs.correct_const", 128'(correct), 128'(1));
        chk("typo_bs.slots12", 128'(text[14:5]), 128'(0));

        // Overflow: 26 letters, first one mismatching so the round stays open
        tg = '0;
        for (int i = 0; i < ML; i++) tg[i*W +: W] = 5'd1;
        cycle("full", 0, 1, 6'd25, tg, 0, 0);
        for (int i = 0; i < 26; i++) begin
            cycle("full", 0, 0, 6'd25, tg, 1, 2 + (i % 20));
            if (i == 24) chk("full.tot25", 128'(tot), 128'(25));
        end
        chk("full.tot_const", 128'(tot), 128'(25));
        chk("full.keys_const", 128'(keys), 128'(26));

        // Backspace at empty, ignored code
        cycle("empty", 0, 1, 6'd3, cat_tg, 0, 0);
        cycle("empty", 0, 0, 6'd3, cat_tg, 1, 0);
        chk("empty_bs.keys_const", 128'(keys), 128'(1));
        chk("empty_bs.tot_const", 128'(tot), 128'(0));
        cycle("empty", 0, 0, 6'd3, cat_tg, 1, 30);
        chk("ignored.keys_const", 128'(keys), 128'(1));

        // Reset mid-round with a key offered
        cycle("rstmid", 0, 1, 6'd3, cat_tg, 0, 0);
        cycle("rstmid", 0, 0, 6'd3, cat_tg, 1, 3);
        cycle("rstmid", 0, 0, 6'd3, cat_tg, 1, 1);
        cycle("rstmid", 1, 0, 6'd3, cat_tg, 1, 20);
        chk("rstmid.tot_const", 128'(tot), 128'(0));
        chk("rstmid.key_ready", 128'(key_ready), 128'(0));
        chk("rstmid.done_const", 128'(done), 128'(0));

        // Start together with a key in TYPING
        cycle("stkey", 0, 1, 6'd3, cat_tg, 0, 0);
        cycle("stkey", 0, 0, 6'd3, cat_tg, 1, 3);
        cycle("stkey", 0, 1, 6'd3, cat_tg, 1, 1);
        chk("stkey.tot_const", 128'(tot), 128'(0));
        chk("stkey.keys_const", 128'(keys), 128'(0));
        cycle("stkey", 0, 0, 6'd3, cat_tg, 0, 0);
        chk("stkey.ready_after", 128'(key_ready), 128'(1));

        // Key counter saturation
        cycle("sat", 0, 1, 6'd3, cat_tg, 0, 0);
        for (int i = 0; i < 1005; i++) cycle("sat", 0, 0, 6'd3, cat_tg, 1, 0);
        chk("sat.keys_const", 128'(keys), 128'(999));

        // Random rounds
        for (int r = 0; r < 14; r++) begin
            len = $urandom_range(1, 8);
            tg = '0;
            for (int i = 0; i < ML; i++) tg[i*W +: W] = W'($urandom_range(1, 26));
            cycle("rnd", 0, 1, 6'(len), tg, 0, 0);
            for (int c = 0; c < 150; c++) begin
                p  = $urandom_range(0, 99);
                q  = $urandom_range(0, 99);
                kv = (p < 85);
                st = (p >= 98);
                if (q < 45)      kc = (m_tot < ML) ? m_target[m_tot] : 1;
                else if (q < 70) kc = 0;
                else if (q < 92) kc = $urandom_range(1, 26);
                else             kc = $urandom_range(27, 31);
                cycle("rnd", 0, st, 6'(len), tg, kv, kc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
